// File: rtl/fill_valve_arbiter_if.sv
// Signal bundle between the laundromat bank controllers and the shared fill-valve arbiter.
// The slave modport is the arbiter's view. The master modport is the bank side.
interface fill_valve_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
);
    logic             enable;
    logic [N_REQ-1:0] fill_req;
    logic [N_REQ-1:0] fill_gnt;
    logic             valve_on;
    logic [IDW-1:0]   active_id;
    logic             busy;
    logic             timeout_pulse;
    logic [IDW-1:0]   timeout_id;

    modport master (
        output enable, fill_req,
        input  fill_gnt, valve_on, active_id, busy, timeout_pulse, timeout_id
    );

    modport slave (
        input  enable, fill_req,
        output fill_gnt, valve_on, active_id, busy, timeout_pulse, timeout_id
    );
endinterface

// File: rtl/fill_valve_arbiter.sv
// Round-robin owner of the mains inlet valve. It grants one machine at a time and bounds each
// grant with MAX_FILL cycles. A GAP_CYC settling gap with the valve closed follows every grant.
module fill_valve_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_FILL = 1024,
    parameter int GAP_CYC  = 2,
    parameter int IDW      = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    fill_valve_arbiter_if.slave bus
);
    localparam int HW = $clog2(MAX_FILL);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_FILL - 1);
    localparam logic [GW-1:0]    GAP_LAST  = GW'(GAP_CYC - 1);
    localparam logic [IDW-1:0]   ID_LAST   = IDW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] GNT_ONE   = N_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // First requester found when scanning upward from ptr, wrapping modulo N_REQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDW-1:0]   ptr);
        logic           found;
        logic [IDW-1:0] win;
        int             idx;
        found = 1'b0;
        win   = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == ID_LAST) ? {IDW{1'b0}} : id + IDW'(1);
    endfunction

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [N_REQ-1:0] fill_gnt_q, fill_gnt_d;
    logic             valve_on_q, valve_on_d;
    logic [IDW-1:0]   active_id_q, active_id_d;
    logic             busy_q, busy_d;
    logic             timeout_pulse_q, timeout_pulse_d;
    logic [IDW-1:0]   timeout_id_q, timeout_id_d;
    logic             release_s;
    logic [IDW-1:0]   win_s;

    // Next state and next registered outputs.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        hold_d          = hold_q;
        gap_d           = gap_q;
        fill_gnt_d      = fill_gnt_q;
        valve_on_d      = valve_on_q;
        active_id_d     = active_id_q;
        busy_d          = busy_q;
        timeout_pulse_d = 1'b0;
        timeout_id_d    = timeout_id_q;
        release_s       = 1'b0;
        win_s           = rr_pick(bus.fill_req, ptr_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.enable && (|bus.fill_req)) begin
                    state_d     = ST_GRANT;
                    fill_gnt_d  = GNT_ONE << win_s;
                    valve_on_d  = 1'b1;
                    active_id_d = win_s;
                    busy_d      = 1'b1;
                    hold_d      = {HW{1'b0}};
                end else begin
                    fill_gnt_d = {N_REQ{1'b0}};
                    valve_on_d = 1'b0;
                    busy_d     = 1'b0;
                end
            end
            ST_GRANT: begin
                // A request drop beats the MAX_FILL boundary, so no timeout in that case.
                if (!bus.enable) begin
                    release_s = 1'b1;
                end else if (!bus.fill_req[active_id_q]) begin
                    release_s = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    release_s       = 1'b1;
                    timeout_pulse_d = 1'b1;
                    timeout_id_d    = active_id_q;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
                if (release_s) begin
                    state_d    = ST_GAP;
                    fill_gnt_d = {N_REQ{1'b0}};
                    valve_on_d = 1'b0;
                    busy_d     = 1'b1;
                    hold_d     = {HW{1'b0}};
                    gap_d      = {GW{1'b0}};
                    ptr_d      = next_id(active_id_q);
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    gap_d   = {GW{1'b0}};
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                fill_gnt_d = {N_REQ{1'b0}};
                valve_on_d = 1'b0;
                busy_d     = 1'b0;
                hold_d     = {HW{1'b0}};
                gap_d      = {GW{1'b0}};
            end
        endcase
    end

    // State and output registers; reset closes the valve at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            ptr_q           <= {IDW{1'b0}};
            hold_q          <= {HW{1'b0}};
            gap_q           <= {GW{1'b0}};
            fill_gnt_q      <= {N_REQ{1'b0}};
            valve_on_q      <= 1'b0;
            active_id_q     <= {IDW{1'b0}};
            busy_q          <= 1'b0;
            timeout_pulse_q <= 1'b0;
            timeout_id_q    <= {IDW{1'b0}};
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            hold_q          <= hold_d;
            gap_q           <= gap_d;
            fill_gnt_q      <= fill_gnt_d;
            valve_on_q      <= valve_on_d;
            active_id_q     <= active_id_d;
            busy_q          <= busy_d;
            timeout_pulse_q <= timeout_pulse_d;
            timeout_id_q    <= timeout_id_d;
        end
    end

    assign bus.fill_gnt      = fill_gnt_q;
    assign bus.valve_on      = valve_on_q;
    assign bus.active_id     = active_id_q;
    assign bus.busy          = busy_q;
    assign bus.timeout_pulse = timeout_pulse_q;
    assign bus.timeout_id    = timeout_id_q;
endmodule

// File: tb/tb_fill_valve_arbiter.sv
// Bench for fill_valve_arbiter: directed scenarios plus a random run against a grant-level model.
module tb_fill_valve_arbiter;
    localparam int N    = 4;
    localparam int MAXF = 16;
    localparam int GAP  = 2;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fill_valve_arbiter_if #(.N_REQ(N), .IDW(IDW)) bus ();

    fill_valve_arbiter #(.N_REQ(N), .MAX_FILL(MAXF), .GAP_CYC(GAP), .IDW(IDW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Grant-level model: who holds the valve, for how long, and closed cycles since the last release.
    logic m_valid;
    int   m_id, m_len, m_closed, m_ptr, m_to_id;
    logic m_pulse;

    // Observation history for the fixed-timeline scenarios (index = edge number).
    logic [N-1:0]   gh[64];
    logic           ph[64];
    logic [IDW-1:0] th[64];

    task automatic model_reset();
        m_valid = 1'b0; m_id = 0; m_len = 0; m_closed = GAP + 1;
        m_ptr = 0; m_to_id = 0; m_pulse = 1'b0;
    endtask

    function automatic int rr_winner(input logic [N-1:0] req, input int p);
        for (int i = 0; i < N; i++) if (req[(p + i) % N]) return (p + i) % N;
        return 0;
    endfunction

    task automatic model_edge(input logic en, input logic [N-1:0] req);
        m_pulse = 1'b0;
        if (m_valid) begin
            if (!en || !req[m_id]) begin
                m_valid = 1'b0; m_closed = 1; m_ptr = (m_id + 1) % N;
            end else if (m_len == MAXF) begin
                m_valid = 1'b0; m_closed = 1; m_ptr = (m_id + 1) % N;
                m_pulse = 1'b1; m_to_id = m_id;
            end else begin
                m_len++;
            end
        end else if (m_closed > GAP && en && req != '0) begin
            m_id = rr_winner(req, m_ptr); m_valid = 1'b1; m_len = 1;
        end else if (m_closed <= GAP) begin
            m_closed++;
        end
    endtask

    // Drive inputs just after an edge, then advance to 1 time unit past the next edge.
    task automatic cyc(input logic en, input logic [N-1:0] req);
        bus.enable   = en;
        bus.fill_req = req;
        @(posedge clk);
        #1;
    endtask

    task automatic record(input int ncyc, input logic [N-1:0] req);
        for (int c = 1; c <= ncyc; c++) begin
            cyc(1'b1, req);
            gh[c] = bus.fill_gnt; ph[c] = bus.timeout_pulse; th[c] = bus.timeout_id;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; bus.enable = 1'b0; bus.fill_req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.enable = 1'b0; bus.fill_req = '0;
        @(posedge clk);
        #1;
        n_total++; if (bus.fill_gnt !== 4'b0000) $display("FAIL reset_gnt got=%b exp=0000", bus.fill_gnt); else n_pass++;
        n_total++; if (bus.valve_on !== 1'b0) $display("FAIL reset_valve got=%b exp=0", bus.valve_on); else n_pass++;
        n_total++; if (bus.active_id !== 2'd0) $display("FAIL reset_active got=%0d exp=0", bus.active_id); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
        n_total++; if (bus.timeout_pulse !== 1'b0) $display("FAIL reset_pulse got=%b exp=0", bus.timeout_pulse); else n_pass++;
        n_total++; if (bus.timeout_id !== 2'd0) $display("FAIL reset_toid got=%0d exp=0", bus.timeout_id); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        cyc(1'b1, 4'b0100);
        n_total++; if (bus.fill_gnt !== 4'b0100) $display("FAIL single_gnt got=%b exp=0100", bus.fill_gnt); else n_pass++;
        n_total++; if (bus.valve_on !== 1'b1) $display("FAIL single_valve got=%b exp=1", bus.valve_on); else n_pass++;
        n_total++; if (bus.active_id !== 2'd2) $display("FAIL single_active got=%0d exp=2", bus.active_id); else n_pass++;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", bus.busy); else n_pass++;
        cyc(1'b1, 4'b0100);
        cyc(1'b1, 4'b0100);
        cyc(1'b1, 4'b0000);
        n_total++; if (bus.fill_gnt !== 4'b0000 || bus.busy !== 1'b1 || bus.timeout_pulse !== 1'b0)
            $display("FAIL single_release got gnt=%b busy=%b pulse=%b exp gnt=0000 busy=1 pulse=0", bus.fill_gnt, bus.busy, bus.timeout_pulse);
        else n_pass++;
        cyc(1'b1, 4'b0000);
        n_total++; if (bus.busy !== 1'b1) $display("FAIL single_gap2 got=%b exp=1", bus.busy); else n_pass++;
        cyc(1'b1, 4'b0000);
        n_total++; if (bus.busy !== 1'b0 || bus.active_id !== 2'd2)
            $display("FAIL single_idle got busy=%b active=%0d exp busy=0 active=2", bus.busy, bus.active_id);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] drop;
        int order[$];
        int closed, gcnt;
        logic prev_on;
        do_reset();
        drop = '0; closed = 0; gcnt = 0; prev_on = 1'b0;
        for (int c = 0; c < 200 && order.size() < 5; c++) begin
            cyc(1'b1, 4'b1111 & ~drop);
            drop = '0;
            n_total++; if (!$onehot0(bus.fill_gnt) || bus.valve_on !== (|bus.fill_gnt))
                $display("FAIL rr_onehot got gnt=%b valve=%b exp onehot0 and valve=|gnt", bus.fill_gnt, bus.valve_on);
            else n_pass++;
            if (bus.fill_gnt != '0) begin
                if (!prev_on) begin
                    order.push_back(int'(bus.active_id));
                    if (order.size() > 1) begin
                        n_total++; if (closed != GAP + 1) $display("FAIL rr_spacing got=%0d exp=%0d", closed, GAP + 1); else n_pass++;
                    end
                    gcnt = 0;
                end
                gcnt++;
                if (gcnt == 10) drop = bus.fill_gnt;
            end else begin
                closed = prev_on ? 1 : closed + 1;
            end
            prev_on = (bus.fill_gnt != '0);
        end
        n_total++; if (order.size() != 5) $display("FAIL rr_count got=%0d exp=5", order.size()); else n_pass++;
        for (int k = 0; k < order.size(); k++) begin
            n_total++; if (order[k] != k % N) $display("FAIL rr_order idx=%0d got=%0d exp=%0d", k, order[k], k % N); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int hi;
        do_reset();
        record(22, 4'b0010);
        hi = 0;
        for (int c = 1; c <= 16; c++) if (gh[c] == 4'b0010) hi++;
        n_total++; if (hi != 16) $display("FAIL to_len got=%0d exp=16", hi); else n_pass++;
        n_total++; if (gh[17] !== 4'b0000) $display("FAIL to_clear got=%b exp=0000", gh[17]); else n_pass++;
        n_total++; if (ph[17] !== 1'b1 || th[17] !== 2'd1)
            $display("FAIL to_pulse got pulse=%b id=%0d exp pulse=1 id=1", ph[17], th[17]);
        else n_pass++;
        n_total++; if (ph[18] !== 1'b0 || ph[16] !== 1'b0)
            $display("FAIL to_width got pre=%b post=%b exp 0 and 0", ph[16], ph[18]);
        else n_pass++;
        n_total++; if (gh[18] !== 4'b0000 || gh[19] !== 4'b0000)
            $display("FAIL to_gap got %b %b exp 0000 0000", gh[18], gh[19]);
        else n_pass++;
        n_total++; if (gh[20] !== 4'b0010) $display("FAIL to_regrant got=%b exp=0010", gh[20]); else n_pass++;
    endtask

    task automatic test_fairness();
        do_reset();
        record(40, 4'b1010);
        n_total++; if (gh[1] !== 4'b0010 || gh[16] !== 4'b0010) $display("FAIL fair_first got %b %b exp 0010", gh[1], gh[16]); else n_pass++;
        n_total++; if (th[17] !== 2'd1 || ph[17] !== 1'b1) $display("FAIL fair_to1 got pulse=%b id=%0d exp 1 1", ph[17], th[17]); else n_pass++;
        n_total++; if (gh[20] !== 4'b1000 || gh[35] !== 4'b1000) $display("FAIL fair_second got %b %b exp 1000", gh[20], gh[35]); else n_pass++;
        n_total++; if (gh[36] !== 4'b0000 || ph[36] !== 1'b1 || th[36] !== 2'd3)
            $display("FAIL fair_to3 got gnt=%b pulse=%b id=%0d exp 0000 1 3", gh[36], ph[36], th[36]);
        else n_pass++;
        n_total++; if (gh[39] !== 4'b0010) $display("FAIL fair_wrap got=%b exp=0010", gh[39]); else n_pass++;
    endtask

    task automatic test_enable();
        int bad;
        do_reset();
        cyc(1'b1, 4'b0001);
        n_total++; if (bus.fill_gnt !== 4'b0001) $display("FAIL en_grant got=%b exp=0001", bus.fill_gnt); else n_pass++;
        cyc(1'b1, 4'b0001);
        cyc(1'b0, 4'b0001);
        n_total++; if (bus.fill_gnt !== 4'b0000 || bus.timeout_pulse !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL en_release got gnt=%b pulse=%b busy=%b exp 0000 0 1", bus.fill_gnt, bus.timeout_pulse, bus.busy);
        else n_pass++;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 4'b1111);
            if (bus.fill_gnt !== 4'b0000 || bus.valve_on !== 1'b0 || bus.timeout_pulse !== 1'b0) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL en_block got=%0d exp=0 bad cycles", bad); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL en_idle_busy got=%b exp=0", bus.busy); else n_pass++;
        cyc(1'b1, 4'b1111);
        n_total++; if (bus.fill_gnt !== 4'b0010) $display("FAIL en_resume got=%b exp=0010", bus.fill_gnt); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(1'b1, 4'b0100);
        cyc(1'b1, 4'b0100);
        n_total++; if (bus.fill_gnt !== 4'b0100) $display("FAIL ar_pre got=%b exp=0100", bus.fill_gnt); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++; if (bus.fill_gnt !== 4'b0000 || bus.valve_on !== 1'b0 || bus.busy !== 1'b0 || bus.timeout_pulse !== 1'b0)
            $display("FAIL ar_clear got gnt=%b valve=%b busy=%b pulse=%b exp all 0", bus.fill_gnt, bus.valve_on, bus.busy, bus.timeout_pulse);
        else n_pass++;
        bus.enable = 1'b0; bus.fill_req = '0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 4'b1111);
        n_total++; if (bus.fill_gnt !== 4'b0001 || bus.active_id !== 2'd0)
            $display("FAIL ar_restart got gnt=%b active=%0d exp 0001 0", bus.fill_gnt, bus.active_id);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [N-1:0] req, exp_gnt;
        logic en;
        do_reset();
        model_reset();
        req = '0;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            en = ($urandom_range(0, 19) != 0);
            cyc(en, req);
            model_edge(en, req);
            exp_gnt = m_valid ? (N'(1) << m_id) : '0;
            n_total++; if (bus.fill_gnt !== exp_gnt) $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, bus.fill_gnt, exp_gnt); else n_pass++;
            n_total++; if (bus.valve_on !== m_valid) $display("FAIL rnd_valve cyc=%0d got=%b exp=%b", c, bus.valve_on, m_valid); else n_pass++;
            n_total++; if (bus.active_id !== IDW'(m_id)) $display("FAIL rnd_active cyc=%0d got=%0d exp=%0d", c, bus.active_id, m_id); else n_pass++;
            n_total++; if (bus.busy !== (m_valid || m_closed <= GAP)) $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, bus.busy, (m_valid || m_closed <= GAP)); else n_pass++;
            n_total++; if (bus.timeout_pulse !== m_pulse) $display("FAIL rnd_pulse cyc=%0d got=%b exp=%b", c, bus.timeout_pulse, m_pulse); else n_pass++;
            n_total++; if (bus.timeout_id !== IDW'(m_to_id)) $display("FAIL rnd_toid cyc=%0d got=%0d exp=%0d", c, bus.timeout_id, m_to_id); else n_pass++;
        end
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.fill_req = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_fairness();
        test_enable();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
